twiddle_gen_12: RTL and testbench
=================================

Name: twiddle_gen_12

Overview:
- Produces per-path twiddle factors W_N^e = cos(2πe/N) − j·sin(2πe/N).
- Output feeds the tw_re/tw_im inputs of the stage-1/2 complex multiplier, frame-synchronised to the butterfly data stream.
- Tracks beat position within an N-point frame (NUM_PARALLEL_PATHS samples per beat).
- Computes each path's exponent and folds a quarter-wave cosine ROM into full-circle values.
- Fixed 2-cycle latency; upstream delays data by 2 to align.

Parameters:
- FFT_N, 512, transform length; power of two, ≥ 4·NUM_PARALLEL_PATHS.
- NUM_PARALLEL_PATHS, 16, samples per beat; power of two.
- GROUP_LEN, 64, inner-group size; sample index m splits as k1 = m / GROUP_LEN, n2 = m % GROUP_LEN.
- TW_WIDTH, 9, signed twiddle width; unity = 2^(TW_WIDTH−2) = 128.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- din_valid  in  1  butterfly data beat present this cycle.
- din_sop  in  1  first beat of frame; qualified by din_valid.
- tw_valid  out  1  tw_re/tw_im valid; din_valid delayed 2.
- tw_re  out  [TW_WIDTH-1:0] × NUM_PARALLEL_PATHS  signed cos term per path.
- tw_im  out  [TW_WIDTH-1:0] × NUM_PARALLEL_PATHS  signed −sin term per path.
- frame_done  out  1  one-cycle pulse with the tw_valid of the last beat of a frame.

Behaviour:
- Reset values: tw_valid = 0, frame_done = 0, all tw_re/tw_im = 0, beat counter = 0, state = IDLE.
- Beats per frame: BEATS = FFT_N / NUM_PARALLEL_PATHS (32 by default). The beat counter is log2(BEATS) bits.
- FSM states:
  - IDLE: waits for din_valid & din_sop. On that beat, uses beat index 0 and goes to RUN with counter = 1.
  - RUN: each din_valid beat uses the current counter, then increments it. On the beat with counter = BEATS−1, the counter wraps to 0 and the FSM returns to IDLE.
  - din_valid = 0 in any state: counter holds; no output beat is generated.
  - din_valid & din_sop in RUN (mid-frame restart): this beat is treated as beat 0 and the counter becomes 1. No error is flagged.
  - din_valid without din_sop in IDLE: ignored, with tw_valid = 0 two cycles later.
- Exponent per path i at beat b:
  - m = b·NUM_PARALLEL_PATHS + i.
  - e = (n2 · k1) mod FFT_N, computed in unsigned arithmetic, log2(FFT_N) bits.
- Stage 1 (cycle +1): registers e[i] for every path, plus valid and last-beat flags.
- Stage 2 (cycle +2):
  - Split e: q = e[MSB:MSB−1], r = e[MSB−2:0], Q = FFT_N/4.
  - T[] is an unsigned cosine magnitude table with Q+1 entries.
  - Fold by quadrant:
    - q0: re = T[r], im = −T[Q−r].
    - q1: re = −T[Q−r], im = −T[r].
    - q2: re = −T[r], im = T[Q−r].
    - q3: re = T[Q−r], im = T[r].
  - Results are registered to the outputs.
- Table contents: T[k] = round(128·cos(2πk/FFT_N)), rounded to nearest with ties away from zero. T[0] = 128, T[Q] = 0. Negation of 128 yields −128; no saturation is needed within 9 bits.
- Outputs hold their last values while tw_valid = 0.
- frame_done asserts only when tw_valid = 1 and the beat was index BEATS−1.
- rst mid-frame: all pipeline valids clear on the next edge, so no stale tw_valid appears afterwards. The FSM returns to IDLE.

Optional Feature:
- Macro: TWIDDLE_GEN_INV_EN.
- When defined:
  - Adds input port inv (1 bit), sampled together with din_sop and held for the frame.
  - When inv = 1, tw_im is negated (conjugate twiddle, for IFFT).
  - tw_re is unchanged.
- When undefined: no inv port; forward FFT only.

Decomposition:
- Package twiddle_pkg holds:
  - the constants FFT_N, NUM_PARALLEL_PATHS, GROUP_LEN, TW_WIDTH, BEATS, QTR;
  - the exponent typedef tw_exp_t;
  - the signed sample typedef tw_t;
  - the state enum {IDLE, RUN}.
- Sub-module twiddle_quarter_rom: registered read of T[] for an index 0..Q, one instance per path. It holds the generated constant table and supports synthesis to LUT or BRAM.

Test Plan:
- Reset, then din_sop + 32 consecutive din_valid beats -> on beats 0..3, all paths output (128, 0). On beat 4, path 1 (e = 1) outputs (128, −2). frame_done pulses exactly once, 2 cycles after beat 31.
- Beat 18, path 0 (m = 288, e = 128) -> (0, −128). Beat 9, path 0 (m = 144, k1 = 2, n2 = 16, e = 32) -> (118, −49).
- Drop din_valid for 3 cycles after beat 10 -> tw_valid is low for exactly those 3 cycles delayed by 2. Beat 11 resumes with the correct values; no beat is skipped.
- Assert din_sop at beat 20 -> that beat outputs beat-0 values (all (128, 0)). The next frame_done comes 31 beats later.
- Assert rst at beat 15 -> tw_valid = 0 from the next cycle onward, with no stale beat. din_valid without din_sop afterwards produces no tw_valid.
- With TWIDDLE_GEN_INV_EN and inv = 1 -> beat 18 path 0 outputs (0, +128). Beat 4 path 1 outputs (128, +2).

Source files
------------

// File: rtl/twiddle_pkg.sv
// rtl/twiddle_pkg.sv - shared constants, types and cosine table builder for twiddle_gen_12
package twiddle_pkg;
    localparam int FFT_N              = 512;
    localparam int NUM_PARALLEL_PATHS = 16;
    localparam int GROUP_LEN          = 64;
    localparam int TW_WIDTH           = 9;
    localparam int BEATS              = FFT_N / NUM_PARALLEL_PATHS;
    localparam int QTR                = FFT_N / 4;
    localparam int EXP_W              = $clog2(FFT_N);
    localparam int BEAT_W             = $clog2(BEATS);
    localparam int ADDR_W             = $clog2(QTR) + 1;
    localparam int MAG_W              = TW_WIDTH - 1;

    typedef logic [EXP_W-1:0]           tw_exp_t;
    typedef logic signed [TW_WIDTH-1:0] tw_t;
    typedef logic [BEAT_W-1:0]          beat_t;
    typedef logic [MAG_W-1:0]           mag_t;
    typedef logic [QTR:0][MAG_W-1:0]    mag_tab_t;
    typedef enum logic {IDLE, RUN}      state_t;

    // e = (n2 * k1) mod FFT_N; the truncating multiply provides the modulo
    function automatic tw_exp_t exp_of(beat_t beat, int path);
        tw_exp_t m;
        tw_exp_t k1;
        tw_exp_t n2;
        m  = tw_exp_t'(beat) * tw_exp_t'(NUM_PARALLEL_PATHS) + tw_exp_t'(path);
        k1 = m >> $clog2(GROUP_LEN);
        n2 = m & tw_exp_t'(GROUP_LEN - 1);
        return k1 * n2;
    endfunction

    function automatic mag_tab_t build_table();
        mag_tab_t t;
        real      a;
        for (int k = 0; k <= QTR; k++) begin
            a    = real'(1 << (TW_WIDTH - 2)) * $cos(2.0 * 3.14159265358979323846 * k / FFT_N);
            t[k] = MAG_W'($rtoi(a + 0.5));
        end
        return t;
    endfunction
endpackage

// File: rtl/twiddle_quarter_rom.sv
// rtl/twiddle_quarter_rom.sv - dual-read registered quarter-wave cosine magnitude table
module twiddle_quarter_rom
    import twiddle_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output mag_t              data_a,
    output mag_t              data_b
);
    localparam mag_tab_t TABLE = build_table();

    always_ff @(posedge clk) begin
        if (rst) begin
            data_a <= '0;
            data_b <= '0;
        end else if (en) begin
            data_a <= TABLE[addr_a];
            data_b <= TABLE[addr_b];
        end
    end
endmodule

// File: rtl/twiddle_gen_12.sv
// rtl/twiddle_gen_12.sv - frame-synchronised twiddle generator, 2-cycle latency; TWIDDLE_GEN_INV_EN adds conjugate (inv) mode
module twiddle_gen_12
    import twiddle_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      din_valid,
    input  logic                                      din_sop,
`ifdef TWIDDLE_GEN_INV_EN
    input  logic                                      inv,
`endif
    output logic                                      tw_valid,
    output logic [NUM_PARALLEL_PATHS-1:0][TW_WIDTH-1:0] tw_re,
    output logic [NUM_PARALLEL_PATHS-1:0][TW_WIDTH-1:0] tw_im,
    output logic                                      frame_done
);
    state_t state;
    beat_t  cnt;
    beat_t  beat;
    logic   fire;
    logic   last;
    logic   inv_in;
    logic   v1;
    logic   last1;
    logic   inv1;
    logic   inv2;

    // a sop beat restarts the frame from any state
    assign fire = din_valid & (din_sop | (state == RUN));
    assign beat = din_sop ? '0 : cnt;
    assign last = (beat == beat_t'(BEATS - 1));

`ifdef TWIDDLE_GEN_INV_EN
    logic inv_frame;
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_frame <= 1'b0;
        end else if (din_valid & din_sop) begin
            inv_frame <= inv;
        end
    end
    assign inv_in = din_sop ? inv : inv_frame;
`else
    assign inv_in = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            v1    <= 1'b0;
            last1 <= 1'b0;
            inv1  <= 1'b0;
        end else begin
            v1    <= fire;
            last1 <= fire & last;
            if (fire) begin
                inv1 <= inv_in;
                if (last) begin
                    cnt   <= '0;
                    state <= IDLE;
                end else begin
                    cnt   <= beat + 1'b1;
                    state <= RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tw_valid   <= 1'b0;
            frame_done <= 1'b0;
            inv2       <= 1'b0;
        end else begin
            tw_valid   <= v1;
            frame_done <= v1 & last1;
            if (v1) begin
                inv2 <= inv1;
            end
        end
    end

    for (genvar i = 0; i < NUM_PARALLEL_PATHS; i++) begin : g_path
        tw_exp_t           e1;
        logic [1:0]        q2;
        logic [ADDR_W-1:0] r1;
        mag_t              mag_r;
        mag_t              mag_c;
        tw_t               pr;
        tw_t               pc;
        tw_t               re;
        tw_t               im;

        always_ff @(posedge clk) begin
            if (rst) begin
                e1 <= '0;
            end else if (fire) begin
                e1 <= exp_of(beat, i);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q2 <= '0;
            end else if (v1) begin
                q2 <= e1[EXP_W-1 -: 2];
            end
        end

        assign r1 = ADDR_W'(e1[EXP_W-3:0]);

        // port a reads T[r], port b reads T[Q-r]
        twiddle_quarter_rom u_rom (
            .clk    (clk),
            .rst    (rst),
            .en     (v1),
            .addr_a (r1),
            .addr_b (ADDR_W'(QTR) - r1),
            .data_a (mag_r),
            .data_b (mag_c)
        );

        assign pr = tw_t'({1'b0, mag_r});
        assign pc = tw_t'({1'b0, mag_c});

        always_comb begin
            re = pr;
            im = -pc;
            case (q2)
                2'd1: begin
                    re = -pc;
                    im = -pr;
                end
                2'd2: begin
                    re = -pr;
                    im = pc;
                end
                2'd3: begin
                    re = pc;
                    im = pr;
                end
                default: begin
                    re = pr;
                    im = -pc;
                end
            endcase
            if (inv2) begin
                im = -im;
            end
        end

        assign tw_re[i] = re;
        assign tw_im[i] = im;
    end
endmodule

// File: tb/tb_twiddle_gen_12.sv
// tb/tb_twiddle_gen_12.sv - self-checking bench for twiddle_gen_12; define TWIDDLE_GEN_INV_EN to exercise inv
module tb_twiddle_gen_12;
    localparam int    N    = 512;
    localparam int    P    = 16;
    localparam int    G    = 64;
    localparam int    B    = N / P;
    localparam int    MAXC = 1023;
    localparam real   PI   = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din_valid = 1'b0;
    logic din_sop = 1'b0;
    logic inv = 1'b0;
    logic tw_valid;
    logic frame_done;
    logic [P-1:0][8:0] tw_re;
    logic [P-1:0][8:0] tw_im;

    twiddle_gen_12 dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_sop    (din_sop),
`ifdef TWIDDLE_GEN_INV_EN
        .inv        (inv),
`endif
        .tw_valid   (tw_valid),
        .tw_re      (tw_re),
        .tw_im      (tw_im),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    bit ov  [0:MAXC];
    bit od  [0:MAXC];
    int ore [0:MAXC][P];
    int oim [0:MAXC][P];

    int mpos    = 0;
    bit inframe = 1'b0;
    bit finv    = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d want %0d", nm, ecnt, act, exp);
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    // W_N^e evaluated directly from the circle, no quarter-wave folding
    task automatic tw_model(input int b, input int i, input bit iv, output int re, output int im);
        int  m;
        int  e;
        real ang;
        m   = b * P + i;
        e   = ((m % G) * (m / G)) % N;
        ang = 2.0 * PI * e / N;
        re  = rnd(128.0 * $cos(ang));
        im  = -rnd(128.0 * $sin(ang));
        if (iv) im = -im;
    endtask

    task automatic step(input bit v, input bit s, input bit r, input bit iv);
        int c;
        int b;
        c = ecnt;
        if (c + 2 > MAXC) begin
            $display("FAIL cycle_budget: cycle %0d exceeds %0d", c, MAXC);
            $fatal(1);
        end
        if (r) begin
            mpos    = 0;
            inframe = 1'b0;
            finv    = 1'b0;
            for (int k = 1; k <= 2; k++) begin
                ov[c+k] = 1'b0;
                od[c+k] = 1'b0;
                for (int i = 0; i < P; i++) begin
                    ore[c+k][i] = 0;
                    oim[c+k][i] = 0;
                end
            end
        end else if (v && (s || inframe)) begin
            b = s ? 0 : mpos;
            if (s) finv = iv;
            ov[c+2] = 1'b1;
            od[c+2] = (b == B - 1);
            for (int i = 0; i < P; i++) tw_model(b, i, finv, ore[c+2][i], oim[c+2][i]);
            mpos    = b + 1;
            inframe = 1'b1;
            if (mpos == B) begin
                mpos    = 0;
                inframe = 1'b0;
            end
        end else begin
            ov[c+2] = 1'b0;
            od[c+2] = 1'b0;
            for (int i = 0; i < P; i++) begin
                ore[c+2][i] = ore[c+1][i];
                oim[c+2][i] = oim[c+1][i];
            end
        end
    endtask

    task automatic cyc(input bit v, input bit s, input bit r, input bit iv);
        din_valid = v;
        din_sop   = s;
        rst       = r;
        inv       = iv;
        step(v, s, r, iv);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        int bad;
        int ar;
        int ai;
        if (ecnt >= 1 && ecnt <= MAXC) begin
            chk("tw_valid", int'(tw_valid), int'(ov[ecnt]));
            chk("frame_done", int'(frame_done), int'(od[ecnt]));
            bad = -1;
            for (int i = 0; i < P; i++) begin
                ar = $signed(tw_re[i]);
                ai = $signed(tw_im[i]);
                if (bad < 0 && (ar != ore[ecnt][i] || ai != oim[ecnt][i])) bad = i;
            end
            n_checks++;
            if (bad < 0) begin
                n_pass++;
            end else begin
                ar = $signed(tw_re[bad]);
                ai = $signed(tw_im[bad]);
                $display("FAIL tw path %0d at cycle %0d: got (%0d,%0d) want (%0d,%0d)",
                         bad, ecnt, ar, ai, ore[ecnt][bad], oim[ecnt][bad]);
            end
            if (frame_done) done_cnt++;
        end
    end

    initial begin
        int re;
        int im;
        for (int k = 0; k <= MAXC; k++) begin
            ov[k] = 1'b0;
            od[k] = 1'b0;
            for (int i = 0; i < P; i++) begin
                ore[k][i] = 0;
                oim[k][i] = 0;
            end
        end

        tw_model(0, 5, 1'b0, re, im);  chk("lit_b0p5_re", re, 128);  chk("lit_b0p5_im", im, 0);
        tw_model(4, 1, 1'b0, re, im);  chk("lit_b4p1_re", re, 128);  chk("lit_b4p1_im", im, -2);
        tw_model(18, 0, 1'b0, re, im); chk("lit_b18p0_re", re, 0);   chk("lit_b18p0_im", im, -128);
        tw_model(9, 0, 1'b0, re, im);  chk("lit_b9p0_re", re, 118);  chk("lit_b9p0_im", im, -49);
`ifdef TWIDDLE_GEN_INV_EN
        tw_model(18, 0, 1'b1, re, im); chk("lit_inv_b18p0_im", im, 128);
        tw_model(4, 1, 1'b1, re, im);  chk("lit_inv_b4p1_im", im, 2);
`endif

        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // full frame with a 3-cycle gap after beat 10
        for (int b = 0; b <= 10; b++) cyc(1'b1, b == 0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int b = 11; b < B; b++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("frame_a_done_count", done_cnt, 1);

        // restart at beat 20
        for (int b = 0; b < 20; b++) cyc(1'b1, b == 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        for (int b = 1; b < B; b++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("frame_b_done_count", done_cnt, 2);

        // beats without sop while idle
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // reset at beat 15, then stray beats
        for (int b = 0; b < 15; b++) cyc(1'b1, b == 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("frame_c_done_count", done_cnt, 2);

`ifdef TWIDDLE_GEN_INV_EN
        // conjugate frame; inv only matters on the sop beat
        for (int b = 0; b < B; b++) cyc(1'b1, b == 0, 1'b0, b == 0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 6; b++) cyc(1'b1, b == 0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("frame_inv_done_count", done_cnt, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
